// File: rtl/approx_err_pkg.sv
// Shared widths and FSM state encodings for the approximate-adder error monitor.
// Pure declarations: no logic, no latency, no flow control.
// Width constants are defaults only; instances override them through module parameters.
package approx_err_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;
    localparam int SUM_W = WIDTH + 1;
    localparam int ACC_W = SUM_W + CNT_W;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/err_calc.sv
// Exact sum of two operands and its unsigned distance to an approximate sum.
// Latency: purely combinational; the parent registers the result.
// Backpressure: none, evaluates every cycle.
module err_calc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH:0]   approx_sum,
    output logic [WIDTH:0]   diff
);

    logic [WIDTH:0] exact;

    always_comb begin
        exact = {1'b0, in1} + {1'b0, in2};
        diff  = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);
    end

endmodule

// File: rtl/approx_err_monitor.sv
// Accumulates error statistics of an external approximate adder over a run of samples.
// Latency: a sample accepted in cycle t shows in the outputs at cycle t+2.
// Backpressure: in_ready high only in RUN until run_len samples have been accepted.
module approx_err_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       run_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in1,
    input  logic [WIDTH-1:0]       in2,
    input  logic [WIDTH:0]         approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH+CNT_W:0]   err_sum,
    output logic [WIDTH:0]         err_max,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       smp_cnt
);
    import approx_err_pkg::*;

    localparam int SW = WIDTH + 1;
    localparam int AW = SW + CNT_W;

    typedef struct packed {
        logic          nz;
        logic [SW-1:0] diff;
    } stage1_t;

    state_t           state;
    logic [CNT_W-1:0] run_len_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             s1_vld;
    logic             s2_vld;
    stage1_t          s1;
    logic [SW-1:0]    diff;
    logic             hs;
    logic             last;

    err_calc #(.WIDTH(WIDTH)) u_err_calc (
        .in1        (in1),
        .in2        (in2),
        .approx_sum (approx_sum),
        .diff       (diff)
    );

    always_comb begin
        in_ready = (state == ST_RUN) && (acc_cnt < run_len_q);
        hs       = in_valid && in_ready;
        last     = hs && (acc_cnt == run_len_q - CNT_W'(1));
        busy     = (state == ST_RUN) || (state == ST_DRAIN);
        done     = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            run_len_q <= '0;
            acc_cnt   <= '0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s1        <= '0;
            err_sum   <= '0;
            err_max   <= '0;
            err_cnt   <= '0;
            smp_cnt   <= '0;
        end else begin
            s1_vld <= hs;
            s2_vld <= s1_vld;
            if (hs) begin
                s1.nz   <= |diff;
                s1.diff <= diff;
                acc_cnt <= acc_cnt + CNT_W'(1);
            end

            if (s1_vld) begin
                err_sum <= err_sum + AW'(s1.diff);
                err_cnt <= err_cnt + CNT_W'(s1.nz);
                smp_cnt <= smp_cnt + CNT_W'(1);
                if (s1.diff > err_max) begin
                    err_max <= s1.diff;
                end
            end

            // Placed after accumulation so a new run's clear always wins.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        run_len_q <= run_len;
                        acc_cnt   <= '0;
                        err_sum   <= '0;
                        err_max   <= '0;
                        err_cnt   <= '0;
                        smp_cnt   <= '0;
                        state     <= (run_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_vld && !s2_vld) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
